pl_mem_wb: RTL and testbench
============================

PL_MEM_WB -- requirements
Module: pl_mem_wb

Interface
REQ-001 Parameter NUM_DOMAINS, default 2: number of 8-bit residue lanes in operation_result and rf_wr_data.
REQ-002 Parameter MEM_TIMEOUT, default 16: maximum number of MEM_WAIT cycles before an access is aborted; legal range 2..255.
REQ-003 clk  in  1  the single rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 EX_reg  in  [0:9]  EX stage flags: [0] store, [1] reg_wr_en, [3] invalidate_execute_instr, [4] load, [8] outp_op, [9] inp_op.
REQ-006 operation_result  in  NUM_DOMAINS*8  EX result; lane 0 is [7:0].
REQ-007 destination_reg_addr  in  4  {RNS_file, addr[2:0]}.
REQ-008 data_wr_addr, data_rd_addr  in  16 each  store and load addresses.
REQ-009 IO_port_ID  in  8  output port ID.
REQ-010 mem_req  out  1; mem_we  out  1; mem_addr  out  16; mem_wdata  out  8: data memory request.
REQ-011 mem_ack  in  1; mem_rdata  in  8: memory completion and load data.
REQ-012 stall  out  1  holds the EX stage and all upstream stages.
REQ-013 rf_wr_en  out  1; rf_wr_addr  out  4; rf_wr_data  out  NUM_DOMAINS*8: register file write port.
REQ-014 out_port_we  out  1; out_port_id  out  8; out_port_data  out  8: output port strobe.
REQ-015 mem_err  out  1  one-cycle pulse when an access times out.

Function
REQ-016 valid SHALL equal !EX_reg[3]; invalid inputs SHALL cause no memory, register-file or port activity.
REQ-017 The FSM SHALL have three states: IDLE, MEM_WAIT and WB_LOAD.
REQ-018 IDLE with valid and EX_reg[0] or EX_reg[4] set SHALL latch:
- address: data_wr_addr for a store, else data_rd_addr;
- mem_we = EX_reg[0];
- mem_wdata = operation_result[7:0];
- destination_reg_addr.
The FSM then SHALL enter MEM_WAIT, and mem_req SHALL rise on the next edge.
REQ-019 If store and load are both set, store SHALL take priority and no register file write SHALL occur.
REQ-020 stall SHALL be combinational and equal (IDLE && valid && (EX_reg[0] || EX_reg[4])) || MEM_WAIT || WB_LOAD.
REQ-021 In MEM_WAIT:
- mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable.
- The cycle counter SHALL increment every cycle.
REQ-022 mem_ack in MEM_WAIT SHALL drop mem_req on the next edge.
- On a store, the FSM then SHALL go to IDLE.
- On a load, it SHALL capture mem_rdata and go to WB_LOAD.
REQ-023 WB_LOAD SHALL assert rf_wr_en for one cycle with the latched address and data {zeros, mem_rdata}, then go to IDLE.
REQ-024 If the counter reaches MEM_TIMEOUT-1 without mem_ack:
- mem_err SHALL pulse for one cycle and mem_req SHALL drop;
- there SHALL be no writeback;
- the FSM SHALL return to IDLE.
REQ-025 mem_ack outside MEM_WAIT SHALL be ignored.
REQ-026 mem_ack on the timeout cycle SHALL win: the access completes normally and there is no mem_err.
REQ-027 IDLE with valid, EX_reg[1] set and no memory op SHALL register rf_wr_en=1, rf_wr_addr=destination_reg_addr and rf_wr_data on the next edge (latency 1).
- rf_wr_data = operation_result when destination_reg_addr[3]=1.
- Otherwise rf_wr_data = {zeros, operation_result[7:0]}.
REQ-028 IDLE with valid and EX_reg[8] set SHALL pulse out_port_we for one cycle on the next edge, with out_port_id=IO_port_ID and out_port_data=operation_result[7:0].
REQ-029 EX_reg[9] (input) SHALL be treated as an ordinary register write of operation_result.
REQ-030 rf_wr_en, out_port_we and mem_err SHALL be single-cycle pulses and SHALL never assert simultaneously from one instruction.
REQ-031 Back-to-back valid non-memory instructions SHALL write on consecutive cycles with no bubble.

Reset
REQ-032 reset low SHALL immediately force the FSM to IDLE and clear the counter and every output register: mem_req, mem_we, mem_addr, mem_wdata, rf_wr_en, rf_wr_addr, rf_wr_data, out_port_we, out_port_id, out_port_data and mem_err.
REQ-033 Reset asserted during MEM_WAIT SHALL abandon the access with no writeback, and a later mem_ack SHALL be ignored.

Verification
REQ-034 ALU write: reg_wr_en=1, dest=4'h3, result=16'hAB12 -> next cycle rf_wr_en=1, addr=3, data=16'h0012; stall stays 0.
REQ-035 Load: load=1, rd_addr=16'h0040; mem_ack on the 3rd MEM_WAIT cycle with rdata=8'h5C -> stall high through WB_LOAD, then rf_wr_en=1, data=16'h005C, then stall=0.
REQ-036 Store: store=1, wr_addr=16'h1234, result[7:0]=8'h77; ack after 1 cycle -> mem_we=1, addr=16'h1234, wdata=8'h77; no rf_wr_en.
REQ-037 Timeout with MEM_TIMEOUT=4 and no ack -> mem_err pulses once, mem_req drops, no rf_wr_en; ack in the final cycle -> no mem_err.
REQ-038 Output port: outp_op=1, IO_port_ID=8'h02, result=8'hF0 -> one-cycle out_port_we, id=2, data=F0.
REQ-039 Reset pulsed low in MEM_WAIT, then mem_ack -> all outputs 0, no writeback, FSM in IDLE.

Source files
------------

// File: rtl/pl_mem_wb.sv
// Memory / writeback pipeline stage: runs data-memory accesses with a bounded
// wait and drives register-file writes and output-port strobes.
module pl_mem_wb #(
  parameter int NUM_DOMAINS = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [0:9]               EX_reg,
  input  logic [NUM_DOMAINS*8-1:0] operation_result,
  input  logic [3:0]               destination_reg_addr,
  input  logic [15:0]              data_wr_addr,
  input  logic [15:0]              data_rd_addr,
  input  logic [7:0]               IO_port_ID,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [15:0]              mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_rdata,
  output logic                     stall,
  output logic                     rf_wr_en,
  output logic [3:0]               rf_wr_addr,
  output logic [NUM_DOMAINS*8-1:0] rf_wr_data,
  output logic                     out_port_we,
  output logic [7:0]               out_port_id,
  output logic [7:0]               out_port_data,
  output logic                     mem_err
);

  localparam int W = NUM_DOMAINS * 8;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, WB_LOAD} state_t;

  state_t       state, next_state;
  logic [7:0]   wait_count;
  logic [3:0]   dest_q;
  logic         is_load_q;

  logic         valid, is_store, is_load, mem_op, alu_wr, port_wr, timeout_now;
  logic [W-1:0] alu_data;
  logic         unused_ex;

  assign valid       = !EX_reg[3];
  assign is_store    = EX_reg[0];
  assign is_load     = EX_reg[4];
  assign mem_op      = valid && (is_store || is_load);
  assign port_wr     = valid && EX_reg[8];
  // An output-port instruction never also writes the register file, so the
  // two strobes can never fire together.
  assign alu_wr      = valid && (EX_reg[1] || EX_reg[9]) && !mem_op && !EX_reg[8];
  assign alu_data    = destination_reg_addr[3] ? operation_result : W'(operation_result[7:0]);
  assign timeout_now = (wait_count == 8'(MEM_TIMEOUT - 1));
  assign unused_ex   = ^{EX_reg[2], EX_reg[5:7]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = mem_op;
        if (mem_op) next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        stall = 1'b1;
        // An acknowledge on the final allowed cycle still completes the access.
        if (mem_ack)          next_state = is_load_q ? WB_LOAD : IDLE;
        else if (timeout_now) next_state = IDLE;
      end
      WB_LOAD: begin
        stall      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      rf_wr_en      <= 1'b0;
      rf_wr_addr    <= '0;
      rf_wr_data    <= '0;
      out_port_we   <= 1'b0;
      out_port_id   <= '0;
      out_port_data <= '0;
      mem_err       <= 1'b0;
      wait_count    <= '0;
      dest_q        <= '0;
      is_load_q     <= 1'b0;
    end else begin
      rf_wr_en    <= 1'b0;
      out_port_we <= 1'b0;
      mem_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            mem_req    <= 1'b1;
            mem_we     <= is_store;
            mem_addr   <= is_store ? data_wr_addr : data_rd_addr;
            mem_wdata  <= operation_result[7:0];
            dest_q     <= destination_reg_addr;
            is_load_q  <= !is_store;
            wait_count <= '0;
          end
          if (alu_wr) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= destination_reg_addr;
            rf_wr_data <= alu_data;
          end
          if (port_wr) begin
            out_port_we   <= 1'b1;
            out_port_id   <= IO_port_ID;
            out_port_data <= operation_result[7:0];
          end
        end
        MEM_WAIT: begin
          wait_count <= wait_count + 8'd1;
          // The load result is registered here so rf_wr_en is high during WB_LOAD.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_load_q) begin
              rf_wr_en   <= 1'b1;
              rf_wr_addr <= dest_q;
              rf_wr_data <= W'(mem_rdata);
            end
          end else if (timeout_now) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_mem_wb.sv
// Self-checking bench for pl_mem_wb: directed scenarios plus randomized
// instructions compared against a cycle-level behavioural model.
module tb_pl_mem_wb;

  localparam int ND  = 2;
  localparam int W   = ND * 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [0:9]    ex = '0;
  logic [W-1:0]  res = '0;
  logic [3:0]    dest = '0;
  logic [15:0]   wr_addr = '0;
  logic [15:0]   rd_addr = '0;
  logic [7:0]    port_id = '0;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = '0;
  logic          mem_req, mem_we, stall, rf_wr_en, out_port_we, mem_err;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_wdata, out_port_id, out_port_data;
  logic [3:0]    rf_wr_addr;
  logic [W-1:0]  rf_wr_data;

  int checks = 0;
  int errors = 0;

  pl_mem_wb #(.NUM_DOMAINS(ND), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .EX_reg(ex), .operation_result(res),
    .destination_reg_addr(dest), .data_wr_addr(wr_addr), .data_rd_addr(rd_addr),
    .IO_port_ID(port_id), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .out_port_we(out_port_we), .out_port_id(out_port_id),
    .out_port_data(out_port_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [0:9] mkEx(input bit st, input bit rw, input bit inv,
                                      input bit ld, input bit op, input bit ip);
    logic [0:9] e;
    e    = '0;
    e[0] = st;
    e[1] = rw;
    e[3] = inv;
    e[4] = ld;
    e[8] = op;
    e[9] = ip;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [0:9] e, input logic [3:0] d, input logic [W-1:0] r,
                               input logic [15:0] wa, input logic [15:0] ra, input logic [7:0] pid);
    ex      = e;
    dest    = d;
    res     = r;
    wr_addr = wa;
    rd_addr = ra;
    port_id = pid;
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, " mem_req"}, 32'(mem_req), 0);
    checkOutput({tag, " mem_we"}, 32'(mem_we), 0);
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 0);
    checkOutput({tag, " mem_wdata"}, 32'(mem_wdata), 0);
    checkOutput({tag, " rf_wr_en"}, 32'(rf_wr_en), 0);
    checkOutput({tag, " rf_wr_addr"}, 32'(rf_wr_addr), 0);
    checkOutput({tag, " rf_wr_data"}, 32'(rf_wr_data), 0);
    checkOutput({tag, " out_port_we"}, 32'(out_port_we), 0);
    checkOutput({tag, " out_port_id"}, 32'(out_port_id), 0);
    checkOutput({tag, " out_port_data"}, 32'(out_port_data), 0);
    checkOutput({tag, " mem_err"}, 32'(mem_err), 0);
    checkOutput({tag, " stall"}, 32'(stall), 0);
  endtask

  // Model of one memory instruction: the request lasts until the ack cycle,
  // or TMO cycles when ackAt is 0 or beyond the limit.
  task automatic memOp(input bit st, input bit ld, input logic [15:0] wa, input logic [15:0] ra,
                       input logic [W-1:0] r, input logic [3:0] d, input int ackAt,
                       input logic [7:0] rdv);
    logic [15:0] expAddr;
    bit          acked;
    int          limit;
    expAddr = st ? wa : ra;
    acked   = (ackAt >= 1) && (ackAt <= TMO);
    limit   = acked ? ackAt : TMO;
    mem_ack = 1'b0;
    applyStimulus(mkEx(st, 1'b0, 1'b0, ld, 1'b0, 1'b0), d, r, wa, ra, 8'($urandom));
    #1;
    checkOutput("mem accept stall", 32'(stall), 1);
    tick();
    applyStimulus('0, 4'($urandom), W'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
    for (int c = 1; c <= limit; c++) begin
      checkOutput("wait mem_req", 32'(mem_req), 1);
      checkOutput("wait mem_we", 32'(mem_we), 32'(st));
      checkOutput("wait mem_addr", 32'(mem_addr), 32'(expAddr));
      checkOutput("wait mem_wdata", 32'(mem_wdata), 32'(r[7:0]));
      checkOutput("wait stall", 32'(stall), 1);
      checkOutput("wait rf_wr_en", 32'(rf_wr_en), 0);
      checkOutput("wait mem_err", 32'(mem_err), 0);
      mem_ack   = (c == ackAt);
      mem_rdata = (c == ackAt) ? rdv : 8'($urandom);
      tick();
    end
    mem_ack = 1'b0;
    checkOutput("done mem_req", 32'(mem_req), 0);
    if (acked) begin
      checkOutput("done mem_err", 32'(mem_err), 0);
      if (!st) begin
        checkOutput("wb rf_wr_en", 32'(rf_wr_en), 1);
        checkOutput("wb rf_wr_addr", 32'(rf_wr_addr), 32'(d));
        checkOutput("wb rf_wr_data", 32'(rf_wr_data), 32'(rdv));
        checkOutput("wb stall", 32'(stall), 1);
        tick();
      end else begin
        checkOutput("store rf_wr_en", 32'(rf_wr_en), 0);
      end
      checkOutput("post rf_wr_en", 32'(rf_wr_en), 0);
      checkOutput("post stall", 32'(stall), 0);
    end else begin
      checkOutput("timeout mem_err", 32'(mem_err), 1);
      checkOutput("timeout rf_wr_en", 32'(rf_wr_en), 0);
      checkOutput("timeout stall", 32'(stall), 0);
      tick();
      checkOutput("timeout pulse end", 32'(mem_err), 0);
      checkOutput("timeout no wb", 32'(rf_wr_en), 0);
    end
  endtask

  initial begin
    int          kind;
    bit          inv;
    bit          expRf, expOut;
    logic [W-1:0] expData;

    #1 reset = 1'b0;
    #1 checkAllClear("reset");
    tick();
    tick();
    checkAllClear("reset hold");
    reset = 1'b1;
    tick();

    // ALU write with a single-lane destination
    applyStimulus(mkEx(0, 1, 0, 0, 0, 0), 4'h3, 16'hAB12, 16'h0, 16'h0, 8'h0);
    #1 checkOutput("alu stall", 32'(stall), 0);
    tick();
    checkOutput("alu rf_wr_en", 32'(rf_wr_en), 1);
    checkOutput("alu rf_wr_addr", 32'(rf_wr_addr), 3);
    checkOutput("alu rf_wr_data", 32'(rf_wr_data), 32'h0012);
    checkOutput("alu stall after", 32'(stall), 0);
    applyStimulus('0, 4'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    tick();
    checkOutput("alu pulse end", 32'(rf_wr_en), 0);

    // Output port strobe
    applyStimulus(mkEx(0, 0, 0, 0, 1, 0), 4'h0, 16'h00F0, 16'h0, 16'h0, 8'h02);
    tick();
    applyStimulus('0, 4'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    checkOutput("port we", 32'(out_port_we), 1);
    checkOutput("port id", 32'(out_port_id), 2);
    checkOutput("port data", 32'(out_port_data), 32'hF0);
    checkOutput("port no rf", 32'(rf_wr_en), 0);
    tick();
    checkOutput("port pulse end", 32'(out_port_we), 0);

    // Invalidated memory instruction does nothing
    applyStimulus(mkEx(1, 1, 1, 1, 1, 0), 4'h1, 16'h1111, 16'h2222, 16'h3333, 8'h4);
    #1 checkOutput("inval stall", 32'(stall), 0);
    tick();
    applyStimulus('0, 4'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    checkOutput("inval mem_req", 32'(mem_req), 0);
    checkOutput("inval rf_wr_en", 32'(rf_wr_en), 0);
    checkOutput("inval port", 32'(out_port_we), 0);

    // Directed memory scenarios
    memOp(0, 1, 16'h9999, 16'h0040, 16'h1234, 4'h5, 3, 8'h5C);
    memOp(1, 0, 16'h1234, 16'h5555, 16'h3377, 4'h2, 1, 8'hAA);
    memOp(1, 1, 16'hBEEF, 16'h0101, 16'h0042, 4'h6, 2, 8'h33);
    memOp(0, 1, 16'h0000, 16'h0F0F, 16'h0000, 4'h9, 0, 8'h00);
    memOp(0, 1, 16'h0000, 16'h0A0A, 16'h0000, 4'hC, TMO, 8'hE7);
    memOp(1, 0, 16'h7777, 16'h0000, 16'h00C3, 4'h0, 0, 8'h00);

    // Randomized back-to-back ALU / input / port instructions with stray acks
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      inv  = ($urandom_range(0, 3) == 0);
      applyStimulus(mkEx(0, kind == 1, inv, 0, kind == 3, kind == 2), 4'($urandom),
                    W'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
      mem_ack   = 1'($urandom);
      mem_rdata = 8'($urandom);
      expRf   = !inv && (kind == 1 || kind == 2);
      expOut  = !inv && (kind == 3);
      expData = dest[3] ? res : {8'h00, res[7:0]};
      #1 checkOutput("rnd stall", 32'(stall), 0);
      tick();
      checkOutput("rnd rf_wr_en", 32'(rf_wr_en), 32'(expRf));
      if (expRf) begin
        checkOutput("rnd rf_wr_addr", 32'(rf_wr_addr), 32'(dest));
        checkOutput("rnd rf_wr_data", 32'(rf_wr_data), 32'(expData));
      end
      checkOutput("rnd out_port_we", 32'(out_port_we), 32'(expOut));
      if (expOut) begin
        checkOutput("rnd out_port_id", 32'(out_port_id), 32'(port_id));
        checkOutput("rnd out_port_data", 32'(out_port_data), 32'(res[7:0]));
      end
      checkOutput("rnd mem_req", 32'(mem_req), 0);
      checkOutput("rnd mem_err", 32'(mem_err), 0);
    end
    mem_ack = 1'b0;
    applyStimulus('0, 4'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    tick();

    // Randomized memory accesses
    for (int i = 0; i < 8; i++) begin
      memOp(1'($urandom), 1'b1, 16'($urandom), 16'($urandom), W'($urandom), 4'($urandom),
            $urandom_range(0, TMO + 1), 8'($urandom));
    end

    // Reset during MEM_WAIT abandons the access; a late ack is ignored
    applyStimulus(mkEx(0, 0, 0, 1, 0, 0), 4'h7, 16'h00FF, 16'h0, 16'h0800, 8'h0);
    tick();
    applyStimulus('0, 4'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    checkOutput("pre-reset mem_req", 32'(mem_req), 1);
    tick();
    reset = 1'b0;
    #1 checkAllClear("async reset");
    #1 reset = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    checkAllClear("after reset ack");
    tick();
    checkAllClear("after reset idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
